// File: rtl/d_flip_flop.sv
// Edge-triggered D register with complementary output and asynchronous active-low reset.
// q is driven straight from the flops; q_bar is derived from q so the two can never disagree.
module d_flip_flop #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

    assign q_bar = ~q;

endmodule

// File: tb/tb_d_flip_flop.sv
// Directed bench for d_flip_flop: a 1-bit default instance and an 8-bit instance with RST_VAL=8'hA5.
// Expected values are queued when stimulus is driven and popped when outputs are sampled.
module tb_d_flip_flop;

    typedef struct {
        logic [7:0] q;
        logic [7:0] mask;
    } sb_t;

    logic       clk = 1'b0;
    logic       reset1;
    logic [0:0] d1;
    logic [0:0] q1;
    logic [0:0] qb1;
    logic       reset8;
    logic [7:0] d8;
    logic [7:0] q8;
    logic [7:0] qb8;

    int   passed = 0;
    int   total  = 0;
    sb_t  sb[$];

    always #5 clk = ~clk;

    d_flip_flop dut1 (
        .clk   (clk),
        .reset (reset1),
        .d     (d1),
        .q     (q1),
        .q_bar (qb1)
    );

    d_flip_flop #(
        .WIDTH   (8),
        .RST_VAL (8'hA5)
    ) dut8 (
        .clk   (clk),
        .reset (reset8),
        .d     (d8),
        .q     (q8),
        .q_bar (qb8)
    );

    task automatic push1(input logic e);
        sb_t s;
        s.q    = {7'b0, e};
        s.mask = 8'h01;
        sb.push_back(s);
    endtask

    task automatic push8(input logic [7:0] e);
        sb_t s;
        s.q    = e;
        s.mask = 8'hFF;
        sb.push_back(s);
    endtask

    task automatic chk(input string tag, input logic [7:0] oq, input logic [7:0] oqb);
        sb_t        s;
        logic [7:0] eqb;
        total++;
        if (sb.size() == 0) begin
            $error("FAIL %s: scoreboard empty, q=%h q_bar=%h", tag, oq, oqb);
        end else begin
            s   = sb.pop_front();
            eqb = ~s.q & s.mask;
            assert (oq === s.q && oqb === eqb) passed++;
            else $error("FAIL %s: q=%h q_bar=%h expected q=%h q_bar=%h", tag, oq, oqb, s.q, eqb);
        end
    endtask

    task automatic chk1(input string tag);
        chk(tag, {7'b0, q1}, {7'b0, qb1});
    endtask

    task automatic chk8(input string tag);
        chk(tag, q8, qb8);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:0] seq [3];
        logic       prev;
        seq[0] = 1'b0;
        seq[1] = 1'b1;
        seq[2] = 1'b0;

        reset1 = 1'b1;
        d1     = 1'b0;
        reset8 = 1'b1;
        d8     = 8'h00;

        // Load a 1 so the asynchronous reset has something to clear.
        @(posedge clk); #1;
        push1(1'b0); chk1("init_capture0");
        @(negedge clk); d1 = 1'b1;
        @(posedge clk); #1;
        push1(1'b1); chk1("load_one");

        // Reset asserted mid-cycle: q clears with no clock edge.
        #2 reset1 = 1'b0;
        #1;
        push1(1'b0); chk1("async_reset_immediate");
        d1 = 1'b1;
        for (int unsigned i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            push1(1'b0); chk1("reset_held_ignores_d");
        end

        // Release between edges: no change until the next rising edge.
        @(negedge clk); reset1 = 1'b1; d1 = 1'b1;
        #1;
        push1(1'b0); chk1("release_no_change");
        @(posedge clk); #1;
        push1(1'b1); chk1("first_capture");
        @(negedge clk); #1;
        push1(1'b1); chk1("falling_edge_hold");

        // d = 0,1,0 changing at the falling edge, checked before and after each rising edge.
        prev = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            d1 = seq[i];
            #1;
            push1(prev); chk1("seq_before_edge");
            @(posedge clk); #1;
            push1(seq[i][0]); chk1("seq_after_edge");
            prev = seq[i][0];
            @(negedge clk);
        end

        // Reset wins at a rising edge with d=1.
        d1 = 1'b1; reset1 = 1'b0;
        @(posedge clk); #1;
        push1(1'b0); chk1("reset_priority");
        @(negedge clk); reset1 = 1'b1;
        #1;
        push1(1'b0); chk1("priority_release_hold");
        @(posedge clk); #1;
        push1(1'b1); chk1("priority_then_capture");

        // X on d propagates, then reset recovers.
        @(negedge clk); d1 = 1'bx;
        @(posedge clk); #1;
        push1(1'bx); chk1("x_propagates");
        #1 reset1 = 1'b0;
        #1;
        push1(1'b0); chk1("x_cleared_by_reset");
        @(negedge clk); reset1 = 1'b1; d1 = 1'b0;

        // 8-bit instance with non-zero reset value.
        #2 reset8 = 1'b0;
        #1;
        push8(8'hA5); chk8("w8_reset_val");
        @(posedge clk); #1;
        push8(8'hA5); chk8("w8_reset_held");
        @(negedge clk); reset8 = 1'b1; d8 = 8'h3C;
        #1;
        push8(8'hA5); chk8("w8_release_no_change");
        @(posedge clk); #1;
        push8(8'h3C); chk8("w8_capture");
        @(negedge clk); d8 = 8'hF0;
        @(posedge clk); #1;
        push8(8'hF0); chk8("w8_capture2");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/d_flip_flop.md
Name: d_flip_flop

Overview:
- Parameterised edge-triggered D-type storage register with true (q) and complementary (q_bar) outputs.
- It is the basic sequential primitive used across the sequential-logic library, for example for pipeline stages, synchronisers and state registers.
- It captures d on every rising clock edge and is forced to a known value by an asynchronous active-low reset.

Parameters:
- WIDTH, 1, bit width of d, q and q_bar; legal range 1..64.
- RST_VAL, {WIDTH{1'b0}}, value q takes while reset is asserted.

Ports:
- clk  input  1  clock; all capture happens on the rising edge.
- reset  input  1  reset; asynchronous and active-low (0 = reset asserted, 1 = normal operation).
- d  input  WIDTH  data to be captured.
- q  output  WIDTH  registered data.
- q_bar  output  WIDTH  bitwise complement of q.

Behaviour:
- Reset assertion:
  - When reset falls to 0, q becomes RST_VAL immediately, independent of clk (asynchronous).
  - q_bar becomes ~RST_VAL at the same time.
- Reset held low: q stays at RST_VAL through any number of clock edges; d is ignored.
- Reset release:
  - reset rising to 1 causes no output change by itself.
  - The first capture happens on the first rising clk edge at which reset is already 1.
- Normal operation (reset = 1): on each rising clk edge, q <= d.
  - Latency is exactly one clock edge.
  - q holds between edges; falling edges have no effect.
- q_bar:
  - Always equals ~q bitwise. It is derived combinationally from the q register, not stored separately, so it can never disagree with q.
  - There is no separate reset path for q_bar.
- Simultaneous events: if reset is 0 at a rising clk edge, reset wins and q = RST_VAL.
- Reset mid-operation: asserting reset between edges overrides the held value at once. Data captured before the reset is lost.
- X handling: if d is X at a capture edge, q and q_bar are X until the next valid capture or reset. No X-masking is applied.
- Timing and structure:
  - Single always block sensitive to posedge clk and negedge reset.
  - No clock gating, no enable, no latches.
  - Output q is driven directly from the flops.

Test Plan:
- Async reset: clk running (period 10), d=0, drive reset=0 mid-cycle -> q=0, q_bar=1 immediately, before the next rising edge; q stays 0 across 2 edges even with d=1.
- Capture: reset=1, d=1 set before an edge -> q=1 and q_bar=0 after that rising edge; q unchanged before the edge and on the falling edge.
- Sequence: reset=1, d = 0,1,0 applied on successive cycles (changing 5 time units after each edge) -> q = 0,1,0 each one edge later; q_bar always the complement.
- Reset priority: d=1 and reset=0 held through a rising edge -> q=0; release reset=1 between edges -> q stays 0 until the next edge, then q=1.
- Reset mid-hold: q=1 with reset=1, assert reset=0 between edges -> q drops to 0 with no clock edge; deassert -> q stays 0 until the next capture.
- Width/RST_VAL: WIDTH=8, RST_VAL=8'hA5, reset=0 -> q=8'hA5, q_bar=8'h5A; release and d=8'h3C -> q=8'h3C, q_bar=8'hC3 after one edge.
